// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned multiply / restoring divide beside the ALU.
// Ports: req_valid/req_ready in, op/bmd/s/t/eflags_as_src operands,
//        resp_valid/resp_ready out, d/r/eflags/eflags_update/div_by_zero.

package muldiv_pkg;
  localparam int REG_W  = 64;
  localparam int CF_BIT = 0;
  localparam int OF_BIT = 11;

  typedef logic [REG_W-1:0] reg_t;

  typedef enum logic [1:0] {
    BMD_08 = 2'd0,
    BMD_16 = 2'd1,
    BMD_32 = 2'd2,
    BMD_64 = 2'd3
  } bmd_t;

  typedef enum logic [2:0] {
    MIOP_NOP = 3'd0,
    MIOP_MUL = 3'd1,
    MIOP_DIV = 3'd2
  } miop_t;
endpackage

module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req_valid,
  output logic  req_ready,
  input  miop_t op,
  input  bmd_t  bmd,
  input  reg_t  s,
  input  reg_t  t,
  input  reg_t  eflags_as_src,
  output logic  resp_valid,
  input  logic  resp_ready,
  output reg_t  d,
  output reg_t  r,
  output reg_t  eflags,
  output logic  eflags_update,
  output logic  div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  function automatic logic [6:0] width_of(input bmd_t b);
    logic [6:0] w;
    unique case (b)
      BMD_08:  w = 7'd8;
      BMD_16:  w = 7'd16;
      BMD_32:  w = 7'd32;
      default: w = 7'd64;
    endcase
    return w;
  endfunction

  // 1 << 64 wraps to 0 in 64 bits, so
  // the 64-bit mask falls out as all ones.
  function automatic reg_t mask_of(input logic [6:0] w);
    return (64'd1 << w) - 64'd1;
  endfunction

  state_t       state;
  miop_t        op_q;
  logic [6:0]   w_q;
  logic [6:0]   cnt;
  reg_t         s_q;
  reg_t         flags_q;
  logic         dbz_q;
  logic [127:0] mc;
  logic [127:0] prod;
  reg_t         mp;
  reg_t         dvd;
  reg_t         dvs;
  reg_t         rem;
  reg_t         quot;

  logic [6:0]   acc_w;
  reg_t         acc_m;
  reg_t         s_m;
  reg_t         t_m;

  always_comb begin
    acc_w = width_of(bmd);
    acc_m = mask_of(acc_w);
    s_m   = s & acc_m;
    t_m   = t & acc_m;
  end

  // Restoring step: bit 64 of diff is the
  // borrow, clear when trial >= divisor.
  logic [64:0]  trial;
  logic [64:0]  diff;
  logic         ge;

  assign trial = {rem, dvd[REG_W-1]};
  assign diff  = trial - {1'b0, dvs};
  assign ge    = ~diff[64];

  logic         hi_nz;
  logic         last;
  reg_t         mul_flags;

  assign hi_nz = |(prod >> w_q);
  assign last  = (cnt == w_q - 7'd1);

  always_comb begin
    mul_flags         = flags_q;
    mul_flags[CF_BIT] = hi_nz;
    mul_flags[OF_BIT] = hi_nz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= MIOP_NOP;
      w_q           <= 7'd64;
      cnt           <= '0;
      s_q           <= '0;
      flags_q       <= '0;
      dbz_q         <= 1'b0;
      mc            <= '0;
      prod          <= '0;
      mp            <= '0;
      dvd           <= '0;
      dvs           <= '0;
      rem           <= '0;
      quot          <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      d             <= '0;
      r             <= '0;
      eflags        <= '0;
      eflags_update <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= op;
            w_q       <= acc_w;
            cnt       <= '0;
            s_q       <= s_m;
            flags_q   <= eflags_as_src;
            dbz_q     <= (op == MIOP_DIV) && (t_m == '0);
            mc        <= {64'd0, s_m};
            prod      <= '0;
            mp        <= t_m;
            // Left-justify the dividend so the
            // next bit is always dvd[63].
            dvd       <= s_m << (7'd64 - acc_w);
            dvs       <= t_m;
            rem       <= '0;
            quot      <= '0;
            req_ready <= 1'b0;
            unique case (1'b1)
              op == MIOP_MUL:
                state <= MUL;
              op == MIOP_DIV && t_m != '0:
                state <= DIV;
              default:
                state <= DONE;
            endcase
          end
        end
        MUL: begin
          if (mp[0]) begin
            prod <= prod + mc;
          end
          mc  <= mc << 1;
          mp  <= mp >> 1;
          cnt <= cnt + 7'd1;
          if (last) begin
            state <= DONE;
          end
        end
        DIV: begin
          rem  <= ge ? diff[63:0] : trial[63:0];
          quot <= {quot[62:0], ge};
          dvd  <= dvd << 1;
          cnt  <= cnt + 7'd1;
          if (last) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            unique case (1'b1)
              op_q == MIOP_MUL: begin
                d             <= prod[63:0] & mask_of(w_q);
                r             <= '0;
                eflags        <= mul_flags;
                eflags_update <= 1'b1;
                div_by_zero   <= 1'b0;
              end
              op_q == MIOP_DIV && dbz_q: begin
                d             <= '0;
                r             <= s_q;
                eflags        <= flags_q;
                eflags_update <= 1'b0;
                div_by_zero   <= 1'b1;
              end
              op_q == MIOP_DIV && !dbz_q: begin
                d             <= quot;
                r             <= rem;
                eflags        <= flags_q;
                eflags_update <= 1'b0;
                div_by_zero   <= 1'b0;
              end
              default: begin
                d             <= '0;
                r             <= '0;
                eflags        <= flags_q;
                eflags_update <= 1'b0;
                div_by_zero   <= 1'b0;
              end
            endcase
          end else if (resp_ready) begin
            resp_valid    <= 1'b0;
            req_ready     <= 1'b1;
            d             <= '0;
            r             <= '0;
            eflags        <= '0;
            eflags_update <= 1'b0;
            div_by_zero   <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors for muldiv_seq checked against
// an arithmetic model every cycle, plus literal pins.

module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  req_valid;
  logic  req_ready;
  miop_t op;
  bmd_t  bmd;
  reg_t  s;
  reg_t  t;
  reg_t  eflags_as_src;
  logic  resp_valid;
  logic  resp_ready;
  reg_t  d;
  reg_t  r;
  reg_t  eflags;
  logic  eflags_update;
  logic  div_by_zero;

  muldiv_seq dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .op            (op),
    .bmd           (bmd),
    .s             (s),
    .t             (t),
    .eflags_as_src (eflags_as_src),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .d             (d),
    .r             (r),
    .eflags        (eflags),
    .eflags_update (eflags_update),
    .div_by_zero   (div_by_zero)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    reg_t d;
    reg_t r;
    reg_t ef;
    logic upd;
    logic dbz;
    int   lat;
  } exp_t;

  function automatic exp_t model(
    input miop_t o, input bmd_t b,
    input reg_t sv, input reg_t tv,
    input reg_t fl);
    exp_t         e;
    int           w;
    logic [127:0] m;
    logic [127:0] p;
    reg_t         sm;
    reg_t         tm;
    w = (b == BMD_08) ? 8 :
        (b == BMD_16) ? 16 :
        (b == BMD_32) ? 32 : 64;
    m  = (128'd1 << w) - 128'd1;
    sm = sv & m[63:0];
    tm = tv & m[63:0];
    e.d   = '0;
    e.r   = '0;
    e.ef  = fl;
    e.upd = 1'b0;
    e.dbz = 1'b0;
    e.lat = 1;
    if (o == MIOP_MUL) begin
      p = {64'd0, sm} * {64'd0, tm};
      e.d      = p[63:0] & m[63:0];
      e.ef[0]  = (p >> w) != 128'd0;
      e.ef[11] = (p >> w) != 128'd0;
      e.upd    = 1'b1;
      e.lat    = w + 1;
    end else if (o == MIOP_DIV) begin
      if (tm == '0) begin
        e.r   = sm;
        e.dbz = 1'b1;
      end else begin
        e.d   = sm / tm;
        e.r   = sm % tm;
        e.lat = w + 1;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  logic pending = 1'b0;
  logic armed   = 1'b0;
  int   acc_cyc = 0;
  exp_t ex;

  int   cap_lat;
  reg_t cap_d;
  reg_t cap_r;
  reg_t cap_ef;
  logic cap_upd;
  logic cap_dbz;

  always @(negedge clk) begin : cmp
    int k;
    if (armed) begin
      if (pending) begin
        k = cyc - acc_cyc;
        if (k < ex.lat) begin
          chk("busy_resp_valid", 64'(resp_valid), 64'd0);
          chk("busy_req_ready", 64'(req_ready), 64'd0);
        end else begin
          chk("resp_valid", 64'(resp_valid), 64'd1);
          chk("req_ready_wait", 64'(req_ready), 64'd0);
          chk("d", d, ex.d);
          chk("r", r, ex.r);
          chk("eflags", eflags, ex.ef);
          chk("eflags_update", 64'(eflags_update), 64'(ex.upd));
          chk("div_by_zero", 64'(div_by_zero), 64'(ex.dbz));
        end
      end else begin
        chk("idle_resp_valid", 64'(resp_valid), 64'd0);
        chk("idle_req_ready", 64'(req_ready), 64'd1);
      end
    end
  end

  // req_valid is held high with scrambled operands while busy,
  // so a wrongly accepted request or a late sample shows up.
  task automatic run_op(input miop_t o, input bmd_t b,
                        input reg_t sv, input reg_t tv,
                        input reg_t fl, input int hold);
    logic seen;
    logic done;
    @(posedge clk);
    #1;
    op            = o;
    bmd           = b;
    s             = sv;
    t             = tv;
    eflags_as_src = fl;
    req_valid     = 1'b1;
    ex            = model(o, b, sv, tv, fl);
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    pending       = 1'b1;
    op            = MIOP_DIV;
    bmd           = BMD_08;
    s             = {$urandom, $urandom};
    t             = {$urandom, $urandom};
    eflags_as_src = ~fl;
    seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (!seen) begin
          seen    = 1'b1;
          cap_lat = cyc - acc_cyc;
          cap_d   = d;
          cap_r   = r;
          cap_ef  = eflags;
          cap_upd = eflags_update;
          cap_dbz = div_by_zero;
        end
        if (hold > 0) begin
          hold--;
          resp_ready = 1'b0;
        end else begin
          resp_ready = 1'b1;
          @(posedge clk);
          #1;
          resp_ready = 1'b0;
          req_valid  = 1'b0;
          pending    = 1'b0;
          done       = 1'b1;
        end
      end
    end
    chk("handoff_in_budget", 64'(done), 64'd1);
    if (!done) begin
      pending   = 1'b0;
      req_valid = 1'b0;
    end
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #1;
    op            = MIOP_MUL;
    bmd           = BMD_64;
    s             = 64'h1234;
    t             = 64'h5678;
    eflags_as_src = 64'hFFFF;
    req_valid     = 1'b1;
    ex            = model(MIOP_MUL, BMD_64, 64'h1234, 64'h5678, 64'hFFFF);
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    pending    = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    pending = 1'b0;
    @(negedge clk);
    chk("rstmid_resp_valid", 64'(resp_valid), 64'd0);
    chk("rstmid_req_ready", 64'(req_ready), 64'd1);
    chk("rstmid_d", d, 64'd0);
    repeat (80) @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  localparam reg_t F1 = 64'h0000_0000_0000_0ED5;
  localparam reg_t F2 = 64'h0000_0000_0000_0246;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst           = 1'b1;
    req_valid     = 1'b0;
    resp_ready    = 1'b0;
    op            = MIOP_NOP;
    bmd           = BMD_64;
    s             = '0;
    t             = '0;
    eflags_as_src = '0;

    e = model(MIOP_MUL, BMD_64, 64'd3, 64'd5, F1);
    chk("pin_mul_d", e.d, 64'd15);
    chk("pin_mul_ef", e.ef, 64'h6D4);
    chk("pin_mul_lat", 64'(e.lat), 64'd65);
    e = model(MIOP_DIV, BMD_32, 64'd100, 64'd7, F2);
    chk("pin_div_d", e.d, 64'd14);
    chk("pin_div_r", e.r, 64'd2);
    e = model(MIOP_MUL, BMD_16, 64'hFFFF, 64'hFFFF, 64'd0);
    chk("pin_mul16_d", e.d, 64'h0001);
    chk("pin_mul16_ef", e.ef, 64'h801);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_d", d, 64'd0);
    chk("rst_r", r, 64'd0);
    chk("rst_eflags", eflags, 64'd0);
    chk("rst_eflags_update", 64'(eflags_update), 64'd0);
    chk("rst_div_by_zero", 64'(div_by_zero), 64'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;

    run_op(MIOP_MUL, BMD_64, 64'd3, 64'd5, F1, 0);
    chk("mul64_lat", 64'(cap_lat), 64'd65);
    chk("mul64_d", cap_d, 64'd15);
    chk("mul64_r", cap_r, 64'd0);
    chk("mul64_ef", cap_ef, 64'h6D4);
    chk("mul64_upd", 64'(cap_upd), 64'd1);

    run_op(MIOP_MUL, BMD_08, 64'hFFFF_FF10, 64'h10, F2, 0);
    chk("mul8_lat", 64'(cap_lat), 64'd9);
    chk("mul8_d", cap_d, 64'd0);
    chk("mul8_ef", cap_ef, 64'hA47);

    run_op(MIOP_DIV, BMD_32, 64'd100, 64'd7, F2, 0);
    chk("div32_lat", 64'(cap_lat), 64'd33);
    chk("div32_d", cap_d, 64'd14);
    chk("div32_r", cap_r, 64'd2);
    chk("div32_ef", cap_ef, F2);
    chk("div32_upd", 64'(cap_upd), 64'd0);

    run_op(MIOP_DIV, BMD_16, 64'h1234, 64'h10000, F2, 0);
    chk("dbz_lat", 64'(cap_lat), 64'd1);
    chk("dbz_flag", 64'(cap_dbz), 64'd1);
    chk("dbz_d", cap_d, 64'd0);
    chk("dbz_r", cap_r, 64'h1234);

    run_op(MIOP_MUL, BMD_64, 64'd6, 64'd7, F2, 10);
    chk("bp_d", cap_d, 64'd42);

    reset_mid();

    run_op(miop_t'(3'd5), BMD_32, 64'd9, 64'd9, F1, 0);
    chk("unsup_lat", 64'(cap_lat), 64'd1);
    chk("unsup_d", cap_d, 64'd0);
    chk("unsup_r", cap_r, 64'd0);
    chk("unsup_ef", cap_ef, F1);
    chk("unsup_upd", 64'(cap_upd), 64'd0);
    chk("unsup_dbz", 64'(cap_dbz), 64'd0);

    run_op(MIOP_DIV, BMD_08, 64'h1FF, 64'h10, F1, 0);
    chk("div8_d", cap_d, 64'h0F);
    chk("div8_r", cap_r, 64'h0F);

    run_op(MIOP_MUL, BMD_16, 64'hFFFF, 64'hFFFF, 64'd0, 2);
    chk("mul16_d", cap_d, 64'h0001);
    chk("mul16_ef", cap_ef, 64'h801);

    run_op(MIOP_MUL, BMD_64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, F2, 0);
    chk("mul64ov_d", cap_d, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mul64ov_ef", cap_ef, 64'hA47);

    run_op(MIOP_DIV, BMD_64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, F1, 0);
    chk("div64_d", cap_d, 64'h5555_5555_5555_5555);
    chk("div64_r", cap_r, 64'd0);
    chk("div64_lat", 64'(cap_lat), 64'd65);

    run_op(MIOP_DIV, BMD_32, 64'd5, 64'd9, F2, 0);
    chk("divsmall_d", cap_d, 64'd0);
    chk("divsmall_r", cap_r, 64'd5);

    run_op(MIOP_MUL, BMD_32, 64'd0, 64'hDEAD_BEEF, F1, 1);
    chk("mulzero_d", cap_d, 64'd0);
    chk("mulzero_ef", cap_ef, 64'h6D4);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
